// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
package serial_rx_pkg;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_t;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial input side, parallel output handshake and status of the receiver.
interface serial_word_receiver_if #(
   parameter int unsigned WIDTH = 4
);
   logic             s_valid;
   logic             s_data;
   logic             s_start;
   logic             s_dir;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             frame_err;
   logic             overrun;
   logic             clr_err;

   // Environment side: drives the serial link, consumes words
   modport master (
      output s_valid, s_data, s_start, s_dir, out_ready, clr_err,
      input  out_data, out_valid, busy, frame_err, overrun
   );

   // Receiver side
   modport slave (
      input  s_valid, s_data, s_start, s_dir, out_ready, clr_err,
      output out_data, out_valid, busy, frame_err, overrun
   );
endinterface

// File: rtl/rx_word_buffer.sv
// Single-entry output holding buffer with valid/ready handshake and sticky overrun.
module rx_word_buffer
   import serial_rx_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_word,
   input  logic             i_ready,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_overrun
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_overrun;
   logic             w_free;

   // Entry can take a new word if empty or being drained this edge
   assign w_free = !r_valid || i_ready;

   // Buffer entry and handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load && w_free) begin
         r_data  <= i_word;
         r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Sticky overrun: a dropped word beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (i_load && !w_free) begin
         r_overrun <= 1'b1;
      end else if (i_clr) begin
         r_overrun <= 1'b0;
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: framed bits in, WIDTH-bit words out (MSB- or LSB-first).
module serial_word_receiver
   import serial_rx_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_word_receiver_if.slave bus
);

   rx_state_t        r_state;
   rx_state_t        w_state_nxt;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] w_sh_nxt;
   logic [WIDTH-1:0] w_sh_first;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic             r_busy;
   logic             r_frame_err;
   logic             w_frame_err_nxt;
   logic             w_complete;
   logic [WIDTH-1:0] w_buf_data;
   logic             w_buf_valid;
   logic             w_buf_overrun;

   // First bit of a frame lands at the end the chosen direction shifts away from
   assign w_sh_first = (bus.s_dir == DIR_LSB_FIRST) ?
                       {bus.s_data, {(WIDTH-1){1'b0}}} :
                       {{(WIDTH-1){1'b0}}, bus.s_data};

   // State, shift register, counter and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RX_IDLE;
         r_sh        <= '0;
         r_cnt       <= '0;
         r_dir       <= DIR_MSB_FIRST;
         r_busy      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sh        <= w_sh_nxt;
         r_cnt       <= w_cnt_nxt;
         r_dir       <= w_dir_nxt;
         r_busy      <= (w_state_nxt == RX_SHIFT);
         r_frame_err <= w_frame_err_nxt;
      end
   end

   // Next-state, shift and completion decode
   always_comb begin
      w_state_nxt     = r_state;
      w_sh_nxt        = r_sh;
      w_cnt_nxt       = r_cnt;
      w_dir_nxt       = r_dir;
      w_complete      = 1'b0;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (bus.s_valid && bus.s_start) begin
               w_dir_nxt   = bus.s_dir;
               w_sh_nxt    = w_sh_first;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = RX_SHIFT;
            end
         end
         RX_SHIFT: begin
            if (bus.s_valid) begin
               if (bus.s_start) begin
                  // Mid-word start: drop the partial word and restart on this bit
                  w_frame_err_nxt = 1'b1;
                  w_dir_nxt       = bus.s_dir;
                  w_sh_nxt        = w_sh_first;
                  w_cnt_nxt       = CNT_W'(1);
               end else begin
                  if (r_dir == DIR_LSB_FIRST) begin
                     w_sh_nxt = {bus.s_data, r_sh[WIDTH-1:1]};
                  end else begin
                     w_sh_nxt = {r_sh[WIDTH-2:0], bus.s_data};
                  end
                  if (r_cnt == CNT_W'(WIDTH-1)) begin
                     w_complete  = 1'b1;
                     w_cnt_nxt   = '0;
                     w_state_nxt = RX_IDLE;
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_W'(1);
                  end
               end
            end
         end
         default: begin
            w_state_nxt = RX_IDLE;
         end
      endcase
   end

   rx_word_buffer #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_complete),
      .i_word    (w_sh_nxt),
      .i_ready   (bus.out_ready),
      .i_clr     (bus.clr_err),
      .o_data    (w_buf_data),
      .o_valid   (w_buf_valid),
      .o_overrun (w_buf_overrun)
   );

   assign bus.out_data  = w_buf_data;
   assign bus.out_valid = w_buf_valid;
   assign bus.overrun   = w_buf_overrun;
   assign bus.busy      = r_busy;
   assign bus.frame_err = r_frame_err;

endmodule
